// File: rtl/round_scorer.sv
// round_scorer: tracks one player's round score and reports playerID, then
// newScore, each held stable for HOLD_CYCLES clocks, followed by a reportDone
// pulse.
// Optional feature macro: ROUND_SCORER_PENALTY_EN (matchMiss decrements the
// score, floor 0). Without it, matchMiss is ignored.
//
// state      | meaning
// S_IDLE     | waiting for roundStart
// S_PLAY     | round in progress, counting hits (and misses)
// S_SEND_ID  | playerID presented, held HOLD_CYCLES cycles
// S_SEND_SCORE | newScore presented, held HOLD_CYCLES cycles
module round_scorer #(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_SCORE   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] curPlayer,
  input  logic       roundStart,
  input  logic       matchHit,
  input  logic       matchMiss,
  input  logic       roundEnd,
  output logic [2:0] playerID,
  output logic [2:0] newScore,
  output logic       reportDone,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_SEND_ID,
    S_SEND_SCORE
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [2:0] SCORE_MAX = 3'(MAX_SCORE);

  state_t     r_state, w_state_next;
  logic [2:0] r_score, w_score_next;
  logic [2:0] r_player, w_player_next;
  logic [3:0] r_timer, w_timer_next;
  logic [2:0] r_player_id, w_player_id_next;
  logic [2:0] r_new_score, w_new_score_next;
  logic       r_done, w_done_next;
  logic [2:0] w_score_hit;
  logic [2:0] w_score_adj;

  // Score after one hit/miss cycle in PLAY (saturating both ways).
  always_comb begin
    w_score_hit = (r_score < SCORE_MAX) ? 3'(r_score + 3'd1) : r_score;
    w_score_adj = r_score;
`ifdef ROUND_SCORER_PENALTY_EN
    if (matchHit && !matchMiss) begin
      w_score_adj = w_score_hit;
    end else if (matchMiss && !matchHit) begin
      w_score_adj = (r_score != 3'd0) ? 3'(r_score - 3'd1) : r_score;
    end
`else
    if (matchHit) begin
      w_score_adj = w_score_hit;
    end
`endif
  end

`ifndef ROUND_SCORER_PENALTY_EN
  logic w_unused_miss;
  assign w_unused_miss = matchMiss;
`endif

  // Next-state, hold timer and report register updates.
  always_comb begin
    w_state_next     = r_state;
    w_score_next     = r_score;
    w_player_next    = r_player;
    w_timer_next     = r_timer;
    w_player_id_next = r_player_id;
    w_new_score_next = r_new_score;
    w_done_next      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (roundStart) begin
          w_state_next  = S_PLAY;
          w_player_next = curPlayer;
          w_score_next  = 3'd0;
        end
      end
      S_PLAY: begin
        if (roundStart) begin
          // Restart wins over a coincident roundEnd.
          w_player_next = curPlayer;
          w_score_next  = 3'd0;
        end else begin
          w_score_next = w_score_adj;
          if (roundEnd) begin
            w_state_next     = S_SEND_ID;
            w_timer_next     = HOLD_LOAD;
            w_player_id_next = r_player;
          end
        end
      end
      S_SEND_ID: begin
        if (r_timer == 4'd0) begin
          w_state_next     = S_SEND_SCORE;
          w_timer_next     = HOLD_LOAD;
          w_new_score_next = r_score;
        end else begin
          w_timer_next = r_timer - 4'd1;
        end
      end
      S_SEND_SCORE: begin
        if (r_timer == 4'd0) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_timer_next = r_timer - 4'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any round or report.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_score     <= 3'd0;
      r_player    <= 3'd0;
      r_timer     <= 4'd0;
      r_player_id <= 3'd0;
      r_new_score <= 3'd0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_score     <= w_score_next;
      r_player    <= w_player_next;
      r_timer     <= w_timer_next;
      r_player_id <= w_player_id_next;
      r_new_score <= w_new_score_next;
      r_done      <= w_done_next;
    end
  end

  assign playerID   = r_player_id;
  assign newScore   = r_new_score;
  assign reportDone = r_done;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_round_scorer.sv
// Directed bench for round_scorer with default parameters (HOLD_CYCLES=4,
// MAX_SCORE=7). Expected scores follow ROUND_SCORER_PENALTY_EN if defined.
module tb_round_scorer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] curPlayer;
  logic       roundStart, matchHit, matchMiss, roundEnd;
  logic [2:0] playerID, newScore;
  logic       reportDone, busy;

  int n_pass  = 0;
  int n_total = 0;

`ifdef ROUND_SCORER_PENALTY_EN
  localparam logic [2:0] EXP_T3 = 3'd1;
  localparam logic [2:0] EXP_T4 = 3'd2;
`else
  localparam logic [2:0] EXP_T3 = 3'd3;
  localparam logic [2:0] EXP_T4 = 3'd3;
`endif

  round_scorer dut (
    .clk       (clk),
    .rst       (rst),
    .curPlayer (curPlayer),
    .roundStart(roundStart),
    .matchHit  (matchHit),
    .matchMiss (matchMiss),
    .roundEnd  (roundEnd),
    .playerID  (playerID),
    .newScore  (newScore),
    .reportDone(reportDone),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called one negedge after the roundEnd edge. Optionally pokes ignored
  // inputs during SEND_ID (roundEnd+hit) and SEND_SCORE (roundStart).
  task automatic run_report(input string tag, input logic [2:0] eid,
                            input logic [2:0] old_score, input logic [2:0] escore,
                            input logic poke);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_id"}, {1'b0, playerID}, {1'b0, eid});
      chk({tag, "_id_oldscore"}, {1'b0, newScore}, {1'b0, old_score});
      chk({tag, "_id_done"}, {3'b0, reportDone}, 4'd0);
      chk({tag, "_id_busy"}, {3'b0, busy}, 4'd1);
      roundEnd = poke && (i == 1);
      matchHit = poke && (i == 1);
      cyc(1);
      roundEnd = 1'b0;
      matchHit = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_sc"}, {1'b0, newScore}, {1'b0, escore});
      chk({tag, "_sc_id"}, {1'b0, playerID}, {1'b0, eid});
      chk({tag, "_sc_done"}, {3'b0, reportDone}, 4'd0);
      chk({tag, "_sc_busy"}, {3'b0, busy}, 4'd1);
      roundStart = poke && (i == 1);
      cyc(1);
      roundStart = 1'b0;
    end
    chk({tag, "_done"}, {3'b0, reportDone}, 4'd1);
    chk({tag, "_done_busy"}, {3'b0, busy}, 4'd0);
    chk({tag, "_done_sc"}, {1'b0, newScore}, {1'b0, escore});
    cyc(1);
    chk({tag, "_done_pulse"}, {3'b0, reportDone}, 4'd0);
    chk({tag, "_idle_busy"}, {3'b0, busy}, 4'd0);
    chk({tag, "_idle_id"}, {1'b0, playerID}, {1'b0, eid});
  endtask

  task automatic start_round(input logic [2:0] p);
    curPlayer  = p;
    roundStart = 1'b1;
    cyc(1);
    roundStart = 1'b0;
  endtask

  task automatic hits(input int n);
    matchHit = 1'b1;
    cyc(n);
    matchHit = 1'b0;
  endtask

  task automatic end_round;
    roundEnd = 1'b1;
    cyc(1);
    roundEnd = 1'b0;
  endtask

  initial begin
    rst = 1'b0; curPlayer = 3'd0;
    roundStart = 1'b0; matchHit = 1'b0; matchMiss = 1'b0; roundEnd = 1'b0;
    cyc(2);
    chk("rst_id", {1'b0, playerID}, 4'd0);
    chk("rst_score", {1'b0, newScore}, 4'd0);
    chk("rst_done", {3'b0, reportDone}, 4'd0);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    rst = 1'b1;
    cyc(1);

    // Player 2, three hits.
    start_round(3'd2);
    chk("t1_busy", {3'b0, busy}, 4'd1);
    hits(3);
    end_round();
    run_report("t1", 3'd2, 3'd0, 3'd3, 1'b0);

    // Player 1, ten hits saturate at 7.
    start_round(3'd1);
    hits(10);
    end_round();
    run_report("t2_sat", 3'd1, 3'd3, 3'd7, 1'b0);

    // Player 5: 2 hits, 3 misses, 1 hit.
    start_round(3'd5);
    hits(2);
    matchMiss = 1'b1; cyc(3); matchMiss = 1'b0;
    hits(1);
    end_round();
    run_report("t3_miss", 3'd5, 3'd7, EXP_T3, 1'b0);

    // Player 3: hit, hit+miss, hit+roundEnd together.
    start_round(3'd3);
    hits(1);
    matchHit = 1'b1; matchMiss = 1'b1; cyc(1); matchMiss = 1'b0;
    roundEnd = 1'b1; cyc(1);
    matchHit = 1'b0; roundEnd = 1'b0;
    run_report("t4_both", 3'd3, EXP_T3, EXP_T4, 1'b0);

    // Restart in PLAY; roundStart beats roundEnd.
    start_round(3'd4);
    hits(2);
    curPlayer = 3'd6; roundStart = 1'b1; roundEnd = 1'b1;
    cyc(1);
    roundStart = 1'b0; roundEnd = 1'b0;
    cyc(2);
    chk("t5_busy", {3'b0, busy}, 4'd1);
    chk("t5_noreport", {1'b0, playerID}, 4'd3);
    hits(1);
    end_round();
    run_report("t5_restart", 3'd6, EXP_T4, 3'd1, 1'b0);

    // Player 0 score 1, then player 2 score 6 with ignored pokes.
    start_round(3'd0);
    hits(1);
    end_round();
    run_report("t6a", 3'd0, 3'd1, 3'd1, 1'b0);
    start_round(3'd2);
    hits(6);
    end_round();
    run_report("t6b", 3'd2, 3'd1, 3'd6, 1'b1);

    // Reset mid-PLAY with score 3.
    start_round(3'd7);
    hits(3);
    rst = 1'b0;
    #1;
    chk("t7_async_busy", {3'b0, busy}, 4'd0);
    chk("t7_async_id", {1'b0, playerID}, 4'd0);
    chk("t7_async_score", {1'b0, newScore}, 4'd0);
    chk("t7_async_done", {3'b0, reportDone}, 4'd0);
    cyc(2);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      chk("t7_no_done", {3'b0, reportDone}, 4'd0);
      chk("t7_idle", {3'b0, busy}, 4'd0);
    end
    end_round();
    cyc(1);
    chk("t7_end_ignored", {3'b0, busy}, 4'd0);
    start_round(3'd1);
    hits(1);
    end_round();
    run_report("t7_after", 3'd1, 3'd0, 3'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/round_scorer.md
ROUND_SCORER -- requirements
Module: round_scorer

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, number of clk cycles each report field is held stable before the next field changes (legal 1..15).
REQ-002 Parameter MAX_SCORE, default 7, saturation ceiling of the round score (legal 1..7).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; 0 resets, 1 runs.
REQ-005 curPlayer  input  3  ID of the player in game, from the access controller; sampled on roundStart.
REQ-006 roundStart  input  1  one-cycle pulse that begins a round.
REQ-007 matchHit  input  1  one-cycle pulse per correct match.
REQ-008 matchMiss  input  1  one-cycle pulse per wrong match.
REQ-009 roundEnd  input  1  one-cycle pulse that ends the round and requests a report.
REQ-010 playerID  output  3  registered player ID presented to the score tracker.
REQ-011 newScore  output  3  registered round total presented to the score tracker.
REQ-012 reportDone  output  1  one-cycle pulse when a report sequence completes.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, PLAY, SEND_ID, SEND_SCORE; encoding free.
REQ-015 IDLE: roundStart -> PLAY next edge; capture curPlayer into internal player register; clear round score to 0; other inputs ignored.
REQ-016 PLAY: matchHit increments score by 1, saturating at MAX_SCORE; no wrap.
REQ-017 PLAY: matchMiss handling per Configuration; matchHit and matchMiss in same cycle -> score unchanged.
REQ-018 PLAY: roundEnd -> SEND_ID; hit/miss in the same cycle as roundEnd is applied before the report is taken.
REQ-019 PLAY: roundStart re-captures curPlayer and clears score (restart), stays in PLAY; roundStart wins over roundEnd in same cycle.
REQ-020 SEND_ID: playerID updated to captured player on entry edge; newScore unchanged; held HOLD_CYCLES cycles, then -> SEND_SCORE.
REQ-021 SEND_SCORE: newScore updated to final round score on entry edge; held HOLD_CYCLES cycles, then -> IDLE with reportDone high for exactly the first IDLE cycle.
REQ-022 playerID and newScore change only on SEND_ID / SEND_SCORE entry edges; hold last reported values in IDLE and PLAY.
REQ-023 In SEND_ID / SEND_SCORE, roundStart, roundEnd, matchHit, matchMiss are ignored (not queued).
REQ-024 Hold timer is a 4-bit down-counter loaded with HOLD_CYCLES-1 on state entry; transition when it reads 0.
REQ-025 Latency roundEnd pulse to reportDone pulse = 2*HOLD_CYCLES+1 cycles.

Reset
REQ-026 rst low asynchronously forces IDLE, playerID=0, newScore=0, reportDone=0, busy=0, score=0, captured player=0, timer=0.
REQ-027 rst asserted mid-round or mid-report aborts with no report and no reportDone; after release, the block waits in IDLE for roundStart.
REQ-028 First state update after rst release occurs on the first rising clk edge with rst high.

Configuration
REQ-029 Macro ROUND_SCORER_PENALTY_EN defined: matchMiss in PLAY decrements score by 1, saturating at 0.
REQ-030 Macro ROUND_SCORER_PENALTY_EN undefined: matchMiss ignored; hit+miss same cycle then increments as a lone hit.

Verification
REQ-031 rst=0 for 2 cycles mid-PLAY with score 3 -> all outputs 0, busy=0, no reportDone after release.
REQ-032 curPlayer=2, roundStart, 3 matchHit, roundEnd -> playerID=2 for 4 cycles, then newScore=3 for 4 cycles, reportDone 9 cycles after roundEnd.
REQ-033 curPlayer=1, roundStart, 10 matchHit, roundEnd -> newScore=7 (saturated), playerID=1.
REQ-034 PENALTY_EN defined: 2 hits, 3 misses, 1 hit -> newScore=1; undefined: same stimulus -> newScore=3.
REQ-035 Round for player 0 score 1, then round for player 2 score 6 -> second report shows playerID=2 before newScore moves from 1 to 6; roundStart during SEND_SCORE ignored, busy stays 1.
